dmem_responder: RTL

- Memory-side responder for the datapath's data-memory interface. Serves one load or store at a time from an internal word-organised RAM.
- Uses a valid/ready request handshake and returns a response a fixed, programmable number of cycles later.
- Sits between the CPU core's data port and the backing store. Lets the core and testbenches exercise non-zero memory latency, byte-enable stores and access-error reporting.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core data port (master)
// and the memory-side responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: word RAM with byte-enable stores,
// fixed programmable response latency and misaligned/out-of-range error reporting.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input logic clk,
    input logic rst,
    dmem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        commit;

    logic        l_we;
    logic [3:0]  l_be;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;

    logic        a_we;
    logic [3:0]  a_be;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_err;
    logic [ADDR_WIDTH-1:0] idx;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    // With LATENCY==1 the commit happens on the acceptance edge itself, so the
    // access fields come straight from the request rather than the latches.
    always_comb begin
        a_we    = l_we;
        a_be    = l_be;
        a_addr  = l_addr;
        a_wdata = l_wdata;
        if (state == IDLE) begin
            a_we    = bus.req_we;
            a_be    = bus.req_be;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
        end
        a_err = (a_addr[1:0] != 2'b00) || (a_addr[31:ADDR_WIDTH+2] != '0);
        idx   = a_addr[ADDR_WIDTH+1:2];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_nxt = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            l_we    <= 1'b0;
            l_be    <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && bus.req_valid) begin
                l_we    <= bus.req_we;
                l_be    <= bus.req_be;
                l_addr  <= bus.req_addr;
                l_wdata <= bus.req_wdata;
            end
            if (commit) begin
                err_q   <= a_err;
                rdata_q <= (!a_we && !a_err) ? mem[idx] : '0;
            end else if (state == RESP) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // RAM is never cleared by reset; a write only lands on a clean commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && a_we && !a_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
